rs_issue_scheduler: RTL and testbench

Issue scheduler between the reservation station and the functional units of the 2-way superscalar core. Each cycle it picks up to two ready RS entries using a rotating-priority scan. It enforces a single non-pipelined multiplier with a busy countdown, and presents registered issue grants to the RS and the FU dispatch stage. Rotation prevents starvation of high-index entries.

---
 rtl/rs_issue_scheduler.sv | 114 +++++++++++
 tb/tb_rs_issue_scheduler.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/rs_issue_scheduler.sv
// Dual-issue scheduler: rotating-priority pick of up to two ready RS entries,
// with a single non-pipelined multiplier tracked by a busy countdown.
module rs_issue_scheduler #(
    parameter int unsigned RS_SIZE  = 8,
    parameter int unsigned MULT_LAT = 4
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic [RS_SIZE-1:0]           i_ready,
    input  logic [RS_SIZE-1:0]           i_is_mult,
    input  logic                         i_stall,
    input  logic                         i_flush,
    output logic [1:0]                   o_issue_valid,
    output logic [2*$clog2(RS_SIZE)-1:0] o_issue_idx,
    output logic [1:0]                   o_issue_mult,
    output logic                         o_mult_busy
);

    localparam int unsigned IW  = $clog2(RS_SIZE);
    localparam int unsigned MCW = $clog2(MULT_LAT) + 1;

    logic [IW-1:0]      r_ptr;
    logic [MCW-1:0]     r_mcnt;
    logic [1:0]         r_issue_valid;
    logic [2*IW-1:0]    r_issue_idx;
    logic [1:0]         r_issue_mult;

    logic               w_mult_free;
    logic [RS_SIZE-1:0] w_elig;
    logic               w_g0_v;
    logic               w_g1_v;
    logic [IW-1:0]      w_g0_idx;
    logic [IW-1:0]      w_g1_idx;
    logic               w_g0_mult;
    logic               w_g1_mult;
    logic               w_accept;
    logic               w_mult_grant;

    assign w_mult_free = (r_mcnt == MCW'(0));

    // Last cycle's grants are masked so the RS has a cycle to drop ready.
    always_comb begin
        w_elig = '0;
        for (int i = 0; i < int'(RS_SIZE); i++) begin
            w_elig[i] = i_ready[i]
                && !(r_issue_valid[0] && r_issue_idx[IW-1:0] == IW'(i))
                && !(r_issue_valid[1] && r_issue_idx[2*IW-1:IW] == IW'(i))
                && (!i_is_mult[i] || w_mult_free);
        end
    end

    // Rotating scan from r_ptr; slot 1 may not take a second multiply.
    always_comb begin
        logic [IW-1:0] scan;
        w_g0_v   = 1'b0;
        w_g1_v   = 1'b0;
        w_g0_idx = '0;
        w_g1_idx = '0;
        scan     = '0;
        for (int k = 0; k < int'(RS_SIZE); k++) begin
            scan = r_ptr + IW'(k);
            if (w_elig[scan]) begin
                if (!w_g0_v) begin
                    w_g0_v   = 1'b1;
                    w_g0_idx = scan;
                end else if (!w_g1_v && !(i_is_mult[w_g0_idx] && i_is_mult[scan])) begin
                    w_g1_v   = 1'b1;
                    w_g1_idx = scan;
                end
            end
        end
    end

    assign w_g0_mult    = w_g0_v && i_is_mult[w_g0_idx];
    assign w_g1_mult    = w_g1_v && i_is_mult[w_g1_idx];
    assign w_accept     = !i_stall && !i_flush;
    assign w_mult_grant = w_accept && (w_g0_mult || w_g1_mult);

    always_ff @(posedge clock) begin
        if (reset) begin
            r_ptr         <= '0;
            r_mcnt        <= '0;
            r_issue_valid <= '0;
            r_issue_idx   <= '0;
            r_issue_mult  <= '0;
        end else begin
            if (w_accept) begin
                r_issue_valid <= {w_g1_v, w_g0_v};
                r_issue_idx   <= {(w_g1_v ? w_g1_idx : IW'(0)), (w_g0_v ? w_g0_idx : IW'(0))};
                r_issue_mult  <= {w_g1_mult, w_g0_mult};
                if (w_g0_v)
                    r_ptr <= (w_g1_v ? w_g1_idx : w_g0_idx) + IW'(1);
            end else begin
                r_issue_valid <= '0;
                r_issue_idx   <= '0;
                r_issue_mult  <= '0;
            end

            // Multiplier occupancy keeps counting down through stalls.
            if (i_flush)
                r_mcnt <= '0;
            else if (w_mult_grant)
                r_mcnt <= MCW'(MULT_LAT - 1);
            else if (r_mcnt != MCW'(0))
                r_mcnt <= r_mcnt - MCW'(1);
        end
    end

    assign o_issue_valid = r_issue_valid;
    assign o_issue_idx   = r_issue_idx;
    assign o_issue_mult  = r_issue_mult;
    assign o_mult_busy   = (r_mcnt != MCW'(0));

endmodule

// File: tb/tb_rs_issue_scheduler.sv
// Scoreboard bench for rs_issue_scheduler: a behavioural model predicts each
// cycle's registered grants, which are queued and compared after the edge.
module tb_rs_issue_scheduler;

    localparam int N   = 8;
    localparam int LAT = 4;

    logic       clock;
    logic       reset;
    logic [7:0] ready;
    logic [7:0] is_mult;
    logic       stall;
    logic       flush;
    logic [1:0] issue_valid;
    logic [5:0] issue_idx;
    logic [1:0] issue_mult;
    logic       mult_busy;

    rs_issue_scheduler #(.RS_SIZE(N), .MULT_LAT(LAT)) dut (
        .clock         (clock),
        .reset         (reset),
        .i_ready       (ready),
        .i_is_mult     (is_mult),
        .i_stall       (stall),
        .i_flush       (flush),
        .o_issue_valid (issue_valid),
        .o_issue_idx   (issue_idx),
        .o_issue_mult  (issue_mult),
        .o_mult_busy   (mult_busy)
    );

    typedef struct {
        logic [1:0] v;
        logic [5:0] idx;
        logic [1:0] m;
        logic       busy;
        logic [2:0] ptr;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    int   m_ptr, m_mcnt;
    int   m_i0, m_i1;
    bit   m_v0, m_v1, m_m0, m_m1;

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    // Reference behaviour: candidate list in rotation order, then pick slots.
    task automatic model_step(input logic [7:0] rdy, input logic [7:0] mul,
                              input bit st, input bit fl, input bit rs);
        exp_t e;
        int   c0, c1, last;
        bit   mgrant;
        c0 = -1;
        c1 = -1;
        if (rs) begin
            m_ptr = 0; m_mcnt = 0;
            m_v0 = 0; m_v1 = 0; m_i0 = 0; m_i1 = 0; m_m0 = 0; m_m1 = 0;
        end else begin
            for (int off = 0; off < N; off++) begin
                int i;
                bit masked;
                i = (m_ptr + off) % N;
                masked = (m_v0 && m_i0 == i) || (m_v1 && m_i1 == i);
                if (rdy[i] && !masked && (!mul[i] || m_mcnt == 0)) begin
                    if (c0 < 0)
                        c0 = i;
                    else if (c1 < 0 && !(mul[c0] && mul[i]))
                        c1 = i;
                end
            end
            mgrant = !st && !fl && ((c0 >= 0 && mul[c0]) || (c1 >= 0 && mul[c1]));
            if (st || fl || c0 < 0) begin
                m_v0 = 0; m_v1 = 0; m_i0 = 0; m_i1 = 0; m_m0 = 0; m_m1 = 0;
            end else begin
                m_v0 = 1;
                m_i0 = c0;
                m_m0 = mul[c0];
                m_v1 = (c1 >= 0);
                m_i1 = (c1 >= 0) ? c1 : 0;
                m_m1 = (c1 >= 0) ? mul[c1] : 1'b0;
                last = (c1 >= 0) ? c1 : c0;
                m_ptr = (last + 1) % N;
            end
            if (fl)
                m_mcnt = 0;
            else if (mgrant)
                m_mcnt = LAT - 1;
            else if (m_mcnt > 0)
                m_mcnt = m_mcnt - 1;
        end
        e.v    = {m_v1, m_v0};
        e.idx  = {3'(m_i1), 3'(m_i0)};
        e.m    = {m_m1, m_m0};
        e.busy = (m_mcnt != 0);
        e.ptr  = 3'(m_ptr);
        sb_q.push_back(e);
    endtask

    task automatic cyc(input logic [7:0] rdy, input logic [7:0] mul,
                       input bit st, input bit fl, input bit rs);
        exp_t e;
        @(negedge clock);
        ready   = rdy;
        is_mult = mul;
        stall   = st;
        flush   = fl;
        reset   = rs;
        model_step(rdy, mul, st, fl, rs);
        @(posedge clock);
        #1;
        if (sb_q.size() == 0) begin
            chk("sb_empty", 32'd1, 32'd0);
        end else begin
            e = sb_q.pop_front();
            chk("issue_valid", 32'(issue_valid), 32'(e.v));
            chk("issue_idx",   32'(issue_idx),   32'(e.idx));
            chk("issue_mult",  32'(issue_mult),  32'(e.m));
            chk("mult_busy",   32'(mult_busy),   32'(e.busy));
            chk("ptr",         32'(dut.r_ptr),   32'(e.ptr));
        end
    endtask

    initial begin
        reset = 1'b1; ready = '0; is_mult = '0; stall = 1'b0; flush = 1'b0;
        m_ptr = 0; m_mcnt = 0; m_v0 = 0; m_v1 = 0; m_i0 = 0; m_i1 = 0; m_m0 = 0; m_m1 = 0;

        // Reset held with everything ready, then one idle cycle.
        cyc(8'hFF, 8'h00, 0, 0, 1);
        cyc(8'hFF, 8'h00, 0, 0, 1);
        chk("rst_valid", 32'(issue_valid), 32'd0);
        cyc(8'h00, 8'h00, 0, 0, 0);
        chk("rst_ptr", 32'(dut.r_ptr), 32'd0);

        // Rotation: 2 and 5, then re-asserted two cycles later.
        cyc(8'b0010_0100, 8'h00, 0, 0, 0);
        chk("rot_idx", 32'(issue_idx), 32'h2A);
        chk("rot_ptr", 32'(dut.r_ptr), 32'd6);
        cyc(8'h00, 8'h00, 0, 0, 0);
        cyc(8'b0010_0100, 8'h00, 0, 0, 0);
        chk("rot2_idx", 32'(issue_idx), 32'h2A);
        cyc(8'h00, 8'h00, 0, 0, 0);

        // Wrap from ptr 6: 7 then 1; then lone 7.
        cyc(8'b1000_0010, 8'h00, 0, 0, 0);
        chk("wrap_idx", 32'(issue_idx), 32'h0F);
        chk("wrap_ptr", 32'(dut.r_ptr), 32'd2);
        cyc(8'h00, 8'h00, 0, 0, 0);
        cyc(8'b1000_0000, 8'h00, 0, 0, 0);
        chk("lone_valid", 32'(issue_valid), 32'd1);
        chk("lone_ptr", 32'(dut.r_ptr), 32'd0);
        cyc(8'h00, 8'h00, 0, 0, 0);

        // Multiplier throttle with an ALU entry slipping in.
        cyc(8'b0000_1001, 8'b0000_1001, 0, 0, 0);
        chk("mul_first", 32'(issue_valid), 32'd1);
        cyc(8'b0000_1000, 8'b0000_1001, 0, 0, 0);
        cyc(8'b0010_1000, 8'b0000_1001, 0, 0, 0);
        cyc(8'b0000_1000, 8'b0000_1001, 0, 0, 0);
        cyc(8'b0000_1000, 8'b0000_1001, 0, 0, 0);
        chk("mul_second", 32'(issue_idx[2:0]), 32'd3);
        cyc(8'h00, 8'h00, 0, 0, 0);
        for (int k = 0; k < 4; k++) cyc(8'h00, 8'h00, 0, 0, 0);

        // Multiply grant immediately followed by flush, mult 4 waiting.
        cyc(8'b0000_0100, 8'b0001_0100, 0, 0, 0);
        cyc(8'b0001_0000, 8'b0001_0100, 0, 1, 0);
        chk("flush_busy", 32'(mult_busy), 32'd0);
        cyc(8'b0001_0000, 8'b0001_0100, 0, 0, 0);
        chk("post_flush", 32'(issue_idx[2:0]), 32'd4);
        cyc(8'h00, 8'h00, 0, 0, 0);

        // Stall for three cycles, then release.
        for (int k = 0; k < 3; k++) cyc(8'h0F, 8'h00, 1, 0, 0);
        cyc(8'h0F, 8'h00, 0, 0, 0);
        cyc(8'h00, 8'h00, 0, 0, 0);

        // Bit 3 held continuously: grant, mask, grant.
        for (int k = 0; k < 4; k++) cyc(8'b0000_1000, 8'h00, 0, 0, 0);
        cyc(8'h00, 8'h00, 0, 0, 0);

        // Random traffic including mid-run resets.
        for (int k = 0; k < 400; k++) begin
            logic [7:0] r, mm;
            bit st, fl, rs;
            r  = 8'($urandom);
            mm = 8'($urandom) & 8'($urandom);
            st = ($urandom_range(0, 9) == 0);
            fl = ($urandom_range(0, 19) == 0);
            rs = ($urandom_range(0, 99) == 0);
            cyc(r, mm, st, fl, rs);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
